// File: rtl/ysyx_25030093_imm_pkg.sv
// Shared immediate-type encodings, pack masks and pack/range helpers for the
// immediate encoder (and the matching extractor).
package ysyx_25030093_imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_U = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_S = 3'b011;
  localparam logic [2:0] IMM_B = 3'b100;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;

  // Scatter imm into the type's bit positions; illegal types return base untouched.
  function automatic logic [31:0] imm_pack(input logic [2:0] t, input logic [31:0] imm,
                                           input logic [31:0] base);
    logic [31:0] mask;
    logic [31:0] field;
    mask  = 32'h0;
    field = 32'h0;
    case (t)
      IMM_I: begin mask = MASK_I; field = {imm[11:0], 20'h0}; end
      IMM_U: begin mask = MASK_U; field = {imm[31:12], 12'h0}; end
      IMM_J: begin mask = MASK_J; field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0}; end
      IMM_S: begin mask = MASK_S; field = {imm[11:5], 13'h0, imm[4:0], 7'h0}; end
      IMM_B: begin mask = MASK_B; field = {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0}; end
      default: begin mask = 32'h0; field = 32'h0; end
    endcase
    return (base & ~mask) | field;
  endfunction

  // True when imm cannot be represented exactly by the type's field.
  function automatic logic imm_range_err(input logic [2:0] t, input logic [31:0] imm);
    logic err;
    err = 1'b1;
    case (t)
      IMM_I, IMM_S: err = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_U:        err = (imm[11:0] != 12'h0);
      IMM_J:        err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      IMM_B:        err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/ysyx_25030093_imm_fifo.sv
// Generic synchronous FIFO; pointers carry one extra bit to tell full from empty.
module ysyx_25030093_imm_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; a full FIFO refuses a push even when a pop frees a slot this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ysyx_25030093_imm_enc.sv
// Immediate encoder: packs imm into base by type and queues it on a valid/ready stream.
// Range checking, out_err and err_sticky exist only when IMM_ENC_CHECK_EN is defined.
module ysyx_25030093_imm_enc
  import ysyx_25030093_imm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        out_err,
  output logic        err_sticky,
  output logic [15:0] enc_count
);

`ifdef IMM_ENC_CHECK_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic [15:0]   enc_count_q;
  logic [15:0]   enc_count_d;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign inst      = empty ? 32'h0 : rdata[31:0];
  assign enc_count = enc_count_q;

  ysyx_25030093_imm_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef IMM_ENC_CHECK_EN
  logic err_now;
  logic err_sticky_q;
  logic err_sticky_d;

  assign err_now    = imm_range_err(imm_type, imm);
  assign wdata      = {err_now, imm_pack(imm_type, imm, base)};
  assign out_err    = empty ? 1'b0 : rdata[32];
  assign err_sticky = err_sticky_q;

  // Sticky error next state.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (push && err_now) begin
      err_sticky_d = 1'b1;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (rst) err_sticky_q <= 1'b0;
    else     err_sticky_q <= err_sticky_d;
  end
`else
  assign wdata      = imm_pack(imm_type, imm, base);
  assign out_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

  // Saturating handshake counter next state.
  always_comb begin
    enc_count_d = enc_count_q;
    if (pop && (enc_count_q != 16'hFFFF)) begin
      enc_count_d = enc_count_q + 16'd1;
    end else begin
      enc_count_d = enc_count_q;
    end
  end

  // Handshake counter register.
  always_ff @(posedge clk) begin
    if (rst) enc_count_q <= 16'h0;
    else     enc_count_q <= enc_count_d;
  end

endmodule

// File: tb/tb_ysyx_25030093_imm_enc.sv
// Table-driven bench for ysyx_25030093_imm_enc plus backpressure and reset-flush sequences.
module tb_ysyx_25030093_imm_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_type;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        out_err;
  logic        err_sticky;
  logic [15:0] enc_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  ysyx_25030093_imm_enc #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_type   (imm_type),
    .imm        (imm),
    .base       (base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inst       (inst),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .enc_count  (enc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic e);
`ifdef IMM_ENC_CHECK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    imm_type = v.t;
    imm      = v.imm;
    base     = v.base;
  endtask

  initial begin
    logic       sticky_exp;
    logic [31:0] head;
    logic       pop_now;
    logic       acc_now;
    int         got;
    vec_t       bp [3];

    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000093, 32'hFFF00093, 1'b0};
    vecs[1]  = '{3'b011, 32'hFFFFFFFC, 32'h00112023, 32'hFE112E23, 1'b0};
    vecs[2]  = '{3'b001, 32'h12345000, 32'h000000B7, 32'h123450B7, 1'b0};
    vecs[3]  = '{3'b100, 32'h00000008, 32'h00000063, 32'h00000463, 1'b0};
    vecs[4]  = '{3'b000, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 1'b0};
    vecs[5]  = '{3'b100, 32'hFFFFFFFE, 32'h00000063, 32'hFE000FE3, 1'b0};
    vecs[6]  = '{3'b010, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0};
    vecs[7]  = '{3'b011, 32'h000007FF, 32'h00000023, 32'h7E000FA3, 1'b0};
    vecs[8]  = '{3'b010, 32'h00000003, 32'h0000006F, 32'h0020006F, 1'b1};
    vecs[9]  = '{3'b000, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
    vecs[10] = '{3'b001, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1};
    vecs[11] = '{3'b100, 32'h00001000, 32'h00000063, 32'h80000063, 1'b1};
    vecs[12] = '{3'b101, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    imm_type = 3'b000; imm = 32'h0; base = 32'h0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready",  {31'h0, in_ready},   32'h1);
    chk("reset_out_valid", {31'h0, out_valid},  32'h0);
    chk("reset_inst",      inst,                32'h0);
    chk("reset_out_err",   {31'h0, out_err},    32'h0);
    chk("reset_sticky",    {31'h0, err_sticky}, 32'h0);
    chk("reset_count",     {16'h0, enc_count},  32'h0);

    // Each vector: accept, check head the next cycle, then pop it.
    sticky_exp = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      sticky_exp = sticky_exp | exp_err(vecs[i].err);
      chk($sformatf("v%0d_out_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("v%0d_inst", i), inst, vecs[i].inst);
      chk($sformatf("v%0d_out_err", i), {31'h0, out_err}, {31'h0, exp_err(vecs[i].err)});
      chk($sformatf("v%0d_sticky", i), {31'h0, err_sticky}, {31'h0, sticky_exp});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_drained", i), {31'h0, out_valid}, 32'h0);
      chk($sformatf("v%0d_count", i), {16'h0, enc_count}, i + 1);
    end

    // Backpressure with a fresh counter.
    rst = 1'b1; tick(); rst = 1'b0;
    bp[0] = vecs[0]; bp[1] = vecs[2]; bp[2] = vecs[3];
    drive(bp[0]); in_valid = 1'b1; tick();
    drive(bp[1]); tick();
    chk("bp_full_in_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_head_a", inst, bp[0].inst);
    drive(bp[2]); tick();
    chk("bp_held_in_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_held_head", inst, bp[0].inst);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      pop_now = out_valid;
      head    = inst;
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) in_valid = 1'b0;
      if (pop_now) begin
        chk($sformatf("bp_order%0d", got), head, bp[got].inst);
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_drained_all", got, 3);
    chk("bp_count", {16'h0, enc_count}, 32'd3);
    chk("bp_empty", {31'h0, out_valid}, 32'h0);

    // Reset flush with one erroneous entry queued.
    drive(vecs[8]); in_valid = 1'b1; tick();
    drive(vecs[0]); tick();
    in_valid = 1'b0;
    chk("flush_pre_sticky", {31'h0, err_sticky}, {31'h0, exp_err(1'b1)});
    chk("flush_pre_inst", inst, vecs[8].inst);
    rst = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("flush_out_valid", {31'h0, out_valid},  32'h0);
    chk("flush_inst",      inst,                32'h0);
    chk("flush_out_err",   {31'h0, out_err},    32'h0);
    chk("flush_sticky",    {31'h0, err_sticky}, 32'h0);
    chk("flush_count",     {16'h0, enc_count},  32'h0);
    chk("flush_in_ready",  {31'h0, in_ready},   32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_imm_enc.md
# ysyx_25030093_imm_enc

Immediate encoder: the inverse of the core's immediate extractor. Accepts a base instruction word with its immediate bit positions don't-care, a 32-bit immediate value and an immediate type. Scatters the immediate into the RISC-V I/U/J/S/B bit positions, checks that the value is representable, and queues the result in an output FIFO. It sits in the self-test and instruction-generation path, feeding synthesized instructions to the instruction memory writer over a valid/ready stream.

## Interface
- DEPTH, 2, output FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept; equals !fifo_full
- imm_type  in  3  000 I, 001 U, 010 J, 011 S, 100 B; 101–111 illegal
- imm  in  32  immediate value, two's complement
- base  in  32  opcode/rd/rs1/rs2/funct fields; immediate positions ignored
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head
- inst  out  32  encoded instruction at FIFO head; 0 when empty
- out_err  out  1  head entry failed range check; 0 when empty
- err_sticky  out  1  set on any accepted entry with error; cleared only by rst
- enc_count  out  16  completed output handshakes, saturating at 0xFFFF

## Operation
- Accept on in_valid && in_ready. Pack combinationally: inst = (base & ~mask[type]) | field[type], then push {inst, err}.
- Placement: I: inst[31:20]=imm[11:0]. U: inst[31:12]=imm[31:12]. J: inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. S: [31:25]=imm[11:5], [11:7]=imm[4:0]. B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- Range check: I/S require imm[31:11] all equal. U requires imm[11:0]==0. J requires imm[0]==0 and imm[31:20] all equal. B requires imm[0]==0 and imm[31:12] all equal. Illegal type is always an error, with inst=base unchanged.
- An error entry is still packed (bits outside the field are dropped) and still queued. It is never discarded.
- Pop on out_valid && out_ready. enc_count increments on pop and holds at 0xFFFF.
- in_ready does not depend on out_ready. When full, a push is refused even if a pop happens that cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged, order preserved.

## Timing
- Reset values: in_ready=1, out_valid=0, inst=0, out_err=0, err_sticky=0, enc_count=0, FIFO empty with pointers at 0.
- Latency: an entry accepted at edge N appears on out_valid/inst after edge N. It is visible in the cycle following acceptance.
- Throughput: one entry per cycle while not full.
- err_sticky rises in the cycle after accepting an erroneous entry.
- rst asserted mid-stream flushes all queued entries at that edge. No output handshake completes in the reset cycle.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

## Configuration
- IMM_ENC_CHECK_EN defined: range checking active as above; out_err and err_sticky driven.
- IMM_ENC_CHECK_EN undefined:
  - No check logic and no err bit in the FIFO.
  - out_err and err_sticky tied to 0.
  - Out-of-range immediates are silently truncated.
  - Illegal types still pass base unchanged.

## Structure
- Package ysyx_25030093_imm_pkg holds:
  - The imm_type encodings IMM_I/IMM_U/IMM_J/IMM_S/IMM_B, shared with the extractor.
  - The pack-mask constants.
  - A pack function.
- Sub-module ysyx_25030093_imm_fifo: generic synchronous FIFO, parameterized by width and DEPTH, with the same clk/rst.

## Test plan
- I-type: base 0x00000093, imm 0xFFFFFFFF → inst 0xFFF00093, out_err 0; out_valid in the cycle after accept.
- S/U-type:
  - base 0x00112023, imm 0xFFFFFFFC, S → inst 0xFE112E23.
  - base 0x000000B7, imm 0x12345000, U → 0x123450B7.
  - Both with out_err 0.
- B-type imm 0x00000008, base 0x00000063 → 0x00000463. J-type imm 0x00000003 → out_err 1, err_sticky 1 next cycle and staying 1 across later clean entries.
- Backpressure, DEPTH=2, out_ready=0:
  - Three back-to-back requests → two accepted, in_ready 0, third held.
  - Then out_ready=1 → all three drain in order, enc_count=3.
- Reset flush: two entries queued, one err, rst for one cycle → out_valid 0, inst 0, err_sticky 0, enc_count 0, in_ready 1.
- Illegal type 3'b101, base 0xDEADBEEF → inst 0xDEADBEEF, out_err 1. With IMM_ENC_CHECK_EN undefined, out_err 0.
